// File: rtl/pcileech_cmd_pkg.sv
// ----------------------------------------------------------------------------
// pcileech_cmd_pkg
// Shared definitions for the command responder: protocol constants, the
// 64-bit command word layout, the response queue entry and the serializer
// state encoding.
// ----------------------------------------------------------------------------
package pcileech_cmd_pkg;

    localparam logic [7:0] CMD_MAGIC     = 8'h77;
    localparam logic [1:0] CMD_TYPE_REG  = 2'b11;

    // Byte [15:8] of response dword0: distinguishes read data from write acks.
    localparam logic [7:0] RSP_KIND_READ = 8'h00;
    localparam logic [7:0] RSP_KIND_WACK = 8'h01;

    // Field positions inside the 16-bit byte address.
    localparam int ADDR_BANK_BIT = 15;
    localparam int ADDR_IDX_LSB  = 1;

    typedef struct packed {
        logic [15:0] value;     // [63:48]
        logic [15:0] mask;      // [47:32]
        logic [15:0] addr;      // [31:16]
        logic [1:0]  rsvd_hi;   // [15:14]
        logic        write;     // [13]
        logic        read;      // [12]
        logic [1:0]  rsvd_lo;   // [11:10]
        logic [1:0]  cmd_type;  // [9:8]
        logic [7:0]  magic;     // [7:0]
    } cmd_word_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  kind;
        logic [15:0] value;
    } rsp_entry_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_SEND0,
        SER_SEND1
    } ser_state_t;

    function automatic logic [31:0] rsp_dword0(input rsp_entry_t e);
        return {e.addr, e.kind, CMD_MAGIC};
    endfunction

    function automatic logic [31:0] rsp_dword1(input rsp_entry_t e);
        return {16'h0000, e.value};
    endfunction

endpackage

// File: rtl/pcileech_cmd_responder_if.sv
// ----------------------------------------------------------------------------
// pcileech_cmd_responder_if
// Link between the com core and the command responder.
//   din / din_valid   : 64-bit command words towards the responder (no stall)
//   dout / dout_wr_en : 32-bit response dwords towards the com core TX path
//   dout_ready        : com core TX path can take a dword
// master = com core side, slave = responder side.
// ----------------------------------------------------------------------------
interface pcileech_cmd_responder_if;
    logic [63:0] din;
    logic        din_valid;
    logic [31:0] dout;
    logic        dout_wr_en;
    logic        dout_ready;

    modport master (output din, din_valid, dout_ready, input dout, dout_wr_en);
    modport slave  (input din, din_valid, dout_ready, output dout, dout_wr_en);
endinterface

// File: rtl/pcileech_cmd_rspq.sv
// ----------------------------------------------------------------------------
// pcileech_cmd_rspq
// Synchronous show-ahead FIFO of response entries.
//   clk, rst       : clock, synchronous active-high reset
//   wr_en, wr_data : push (ignored when full)
//   rd_en, rd_data : pop (ignored when empty); rd_data is the current head
//   full, empty    : status
//   count          : number of stored entries
// ----------------------------------------------------------------------------
module pcileech_cmd_rspq
    import pcileech_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  rsp_entry_t               wr_data,
    input  logic                     rd_en,
    output rsp_entry_t               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];

    rsp_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count define
    // validity, and leaving the array out of reset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pcileech_cmd_responder.sv
// ----------------------------------------------------------------------------
// pcileech_cmd_responder
// Responder end of the command protocol carried by the com core. Decodes
// 64-bit register commands, applies masked writes to an RW register bank,
// samples RW/RO registers for reads and streams each response as two dwords.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : din/din_valid in, dout/dout_wr_en out, dout_ready in
//   ro_regs      : NUM_REGS x 16-bit status inputs, reg i at [16i+15:16i]
//   rw_regs      : NUM_REGS x 16-bit control registers, same packing
//   rsp_overflow : sticky, a response was dropped on a full queue
//   err_cnt      : saturating count of rejected command words
// Build option: define PCILEECH_CMD_RSP_WRITE_ACK_EN to also answer
// write-only commands with the post-write value (kind byte 8'h01).
// ----------------------------------------------------------------------------
module pcileech_cmd_responder
    import pcileech_cmd_pkg::*;
#(
    parameter int                     NUM_REGS  = 16,
    parameter int                     RSP_DEPTH = 4,
    parameter logic [NUM_REGS*16-1:0] RW_RESET  = {NUM_REGS{16'h0000}}
) (
    input  logic                      clk,
    input  logic                      rst,
    pcileech_cmd_responder_if.slave   bus,
    input  logic [NUM_REGS*16-1:0]    ro_regs,
    output logic [NUM_REGS*16-1:0]    rw_regs,
    output logic                      rsp_overflow,
    output logic [7:0]                err_cnt
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

`ifdef PCILEECH_CMD_RSP_WRITE_ACK_EN
    localparam logic WRITE_ACK = 1'b1;
`else
    localparam logic WRITE_ACK = 1'b0;
`endif

    logic [15:0]      rw_q [NUM_REGS];

    cmd_word_t        cmd;
    logic [IDX_W-1:0] idx;
    logic [13:0]      addr_hi;
    logic             bank_rw;
    logic             in_range;
    logic             cmd_ok;
    logic             cmd_bad;
    logic             wr_hit;
    logic [15:0]      wr_val;
    logic [15:0]      rd_val;
    logic             rsp_req;
    rsp_entry_t       rsp_entry;

    rsp_entry_t       q_head;
    logic             q_full;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;
    logic             q_push;
    logic             q_pop;

    ser_state_t       state;
    logic [31:0]      dout_q;
    logic             dout_wr_en_q;

    assign cmd = cmd_word_t'(bus.din);

    // Reserved command bits carry no meaning.
    logic unused_rsvd;
    assign unused_rsvd = ^{cmd.rsvd_hi, cmd.rsvd_lo};

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        idx       = cmd.addr[IDX_W:ADDR_IDX_LSB];
        addr_hi   = cmd.addr[ADDR_BANK_BIT-1:ADDR_IDX_LSB];
        bank_rw   = cmd.addr[ADDR_BANK_BIT];
        // Any address bit above the index field makes the index out of range.
        in_range  = ((addr_hi >> IDX_W) == '0);
        cmd_ok    = bus.din_valid && (cmd.magic == CMD_MAGIC) &&
                    (cmd.cmd_type == CMD_TYPE_REG) && (cmd.read || cmd.write);
        cmd_bad   = bus.din_valid && !cmd_ok;
        wr_hit    = cmd_ok && cmd.write && bank_rw && in_range;
        wr_val    = (rw_q[idx] & ~cmd.mask) | (cmd.value & cmd.mask);

        // Read value reflects a write carried in the same word.
        rd_val = 16'h0000;
        if (in_range) begin
            if (!bank_rw)    rd_val = ro_regs[{idx, 4'h0} +: 16];
            else if (wr_hit) rd_val = wr_val;
            else             rd_val = rw_q[idx];
        end

        rsp_req         = cmd_ok && (cmd.read || (WRITE_ACK && cmd.write));
        rsp_entry.addr  = cmd.addr;
        rsp_entry.kind  = cmd.read ? RSP_KIND_READ : RSP_KIND_WACK;
        rsp_entry.value = rd_val;
    end

    always_comb begin
        rw_regs = '0;
        for (int i = 0; i < NUM_REGS; i++) rw_regs[i*16 +: 16] = rw_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) rw_q[i] <= RW_RESET[i*16 +: 16];
            err_cnt      <= 8'h00;
            rsp_overflow <= 1'b0;
        end else begin
            if (wr_hit) rw_q[idx] <= wr_val;
            if (cmd_bad && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            if (rsp_req && q_full) rsp_overflow <= 1'b1;
        end
    end

    // Entries land in the queue on the edge that samples the command.
    assign q_push = rsp_req && !q_full;
    assign q_pop  = (state == SER_SEND1) && bus.dout_ready;

    pcileech_cmd_rspq #(
        .DEPTH(RSP_DEPTH)
    ) u_rspq (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (rsp_req),
        .wr_data(rsp_entry),
        .rd_en  (q_pop),
        .rd_data(q_head),
        .full   (q_full),
        .empty  (q_empty),
        .count  (q_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SER_IDLE;
            dout_q       <= 32'h0;
            dout_wr_en_q <= 1'b0;
        end else begin
            dout_wr_en_q <= 1'b0;
            case (state)
                SER_IDLE: begin
                    if (!q_empty) state <= SER_SEND0;
                end
                SER_SEND0: begin
                    if (bus.dout_ready) begin
                        dout_q       <= rsp_dword0(q_head);
                        dout_wr_en_q <= 1'b1;
                        state        <= SER_SEND1;
                    end
                end
                SER_SEND1: begin
                    if (bus.dout_ready) begin
                        dout_q       <= rsp_dword1(q_head);
                        dout_wr_en_q <= 1'b1;
                        // A push landing this cycle also keeps the stream going.
                        state <= ((q_count > CNT_W'(1)) || q_push) ? SER_SEND0 : SER_IDLE;
                    end
                end
                default: state <= SER_IDLE;
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_wr_en = dout_wr_en_q;

endmodule

// File: doc/pcileech_cmd_responder.md
Name: pcileech_cmd_responder

Overview:
- FIFO-side endpoint of the buffered communication core.
- Consumes the 64-bit command words the com core delivers in the clk domain and applies register writes to a control/status register bank.
- Returns read responses as a 32-bit word stream into the com core TX path.
- Owns the responder end of the command protocol that the com core transports but never interprets.

Parameters:
- NUM_REGS, 16, registers per bank (RO and RW), power of two, 2..64.
- RSP_DEPTH, 4, response queue depth in 64-bit entries, power of two, ≥2.
- RW_RESET, {NUM_REGS{16'h0000}}, flat reset image of the RW bank (reg 0 in bits [15:0]).

Ports:
- clk  in  1  100MHz system clock.
- rst  in  1  synchronous active-high reset.
- din  in  64  command word from com core.
- din_valid  in  1  din qualifier; no back-pressure exists.
- dout  out  32  response dword to com core TX.
- dout_wr_en  out  1  dout qualifier.
- dout_ready  in  1  com core can accept a dword (not almost-full).
- ro_regs  in  NUM_REGS*16  status inputs, reg i at bits [16i+15:16i].
- rw_regs  out  NUM_REGS*16  control register bank, same packing.
- rsp_overflow  out  1  sticky: a response was lost; cleared only by rst.
- err_cnt  out  8  saturating count of rejected command words.

Behaviour:
- Command word format:
  - [7:0] magic = 8'h77.
  - [9:8] type; 2'b11 = register command.
  - [12] read.
  - [13] write.
  - [31:16] byte address: [15] = bank (1 = RW, 0 = RO), [log2(NUM_REGS):1] = index, [0] ignored.
  - [47:32] write mask.
  - [63:48] write value.
- Accept: din_valid & magic ok & type 2'b11 & (read | write). Any other valid word increments err_cnt (saturates at 8'hFF) and is otherwise ignored.
- Out-of-range index (address bits above the index field nonzero): the command is still accepted. A write to it is discarded; a read of it returns 16'h0000.
- Write: rw[idx] <= (rw[idx] & ~mask) | (value & mask), visible on rw_regs the cycle after din_valid. Writes to the RO bank are ignored.
- Read: register sampled the same cycle din_valid is high, after any write in that same word is applied (read+write in one word returns the post-write value). Back-to-back write then read of the same register returns the new value.
- Response entry is 64 bits:
  - dword0 = {addr[15:0], 8'h00, 8'h77}.
  - dword1 = {16'h0000, value[15:0]}.
  - Pushed to the response queue one cycle after din_valid.
- Queue full at push: entry dropped, rsp_overflow <= 1. A push and pop in the same cycle is allowed.
- Serializer FSM:
  - IDLE: queue not empty -> SEND0.
  - SEND0: dout_ready -> output dword0, dout_wr_en = 1 -> SEND1; otherwise hold.
  - SEND1: dout_ready -> output dword1, dout_wr_en = 1, pop entry -> SEND0 if more entries remain, else IDLE.
  - dout_wr_en is asserted only in a cycle where dout_ready is high (registered output; dout_ready is sampled as an input that cycle).
  - Throughput: 2 dwords per entry, no idle cycle between entries.
- Reset values:
  - rw_regs = RW_RESET; dout = 0; dout_wr_en = 0; rsp_overflow = 0; err_cnt = 0.
  - Queue empty; FSM in IDLE.
  - Reset between SEND0 and SEND1 abandons the entry; no dword1 is emitted after rst.
- Latency: din_valid at cycle N -> first possible dword0 at N+2.

Optional Feature:
- Macro PCILEECH_CMD_RSP_WRITE_ACK_EN.
- Defined: every accepted write-only command also queues a response with the post-write value, dword0 byte [15:8] = 8'h01, and the same overflow rules.
- Undefined: write-only commands produce no response. Read responses always carry byte [15:8] = 8'h00 in both builds.

Decomposition:
- Package pcileech_cmd_pkg holds:
  - CMD_MAGIC, CMD_TYPE_REG.
  - Field-position constants.
  - typedef cmd_word_t (packed struct matching the word format).
  - typedef rsp_entry_t.
- Sub-module pcileech_cmd_rspq: synchronous FIFO of rsp_entry_t with full/empty/count.
- Decode, register bank and serializer stay in the top module.

Test Plan:
- Reset, then din = 64'h00000003_80182377 with rw[12] preset to 16'hFFFF -> rw[12] = 16'hFFFC; no dout_wr_en; err_cnt = 0.
- Write 64'hABCD_FFFF_8004_2377, then next cycle read 64'h0000_0000_8004_1377 -> dout = 32'h80040077 then 32'h0000ABCD on consecutive ready cycles.
- ro_regs reg 3 = 16'h1234, read addr 16'h0006 with dout_ready held low 10 cycles -> no dout_wr_en while low; after ready rises, 32'h00060077 then 32'h00001234.
- Six reads with dout_ready low, RSP_DEPTH = 4 -> rsp_overflow = 1; exactly 4 responses drain, in order.
- Words with magic 8'h76, type 2'b01, and flags 0 -> err_cnt = 3; rw_regs unchanged; 300 bad words -> err_cnt = 8'hFF.
- Assert rst for one cycle after the SEND0 dword is emitted -> no further dout_wr_en; all outputs at reset values next cycle.
